// File: rtl/conv_enc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_enc_frame_ctrl
//
// Sequences one PPDU DATA field into a serial convolutional encoder:
//   CLEAR   - one-cycle encoder shift-register clear
//   SERVICE - SVC_BITS zero bits
//   DATA    - 8*Length payload bits taken from the scrambler (valid/ready)
//   TAIL    - TAIL_BITS zero bits to flush the encoder
//   PAD     - zero bits until the frame fills a whole OFDM symbol of NDbps bits
//   DONE    - one-cycle completion pulse, symbol count published on NSym
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-low reset
//   Start      in   frame request, only looked at while idle
//   Length     in   payload length in bytes, latched on an accepted Start
//   NDbps      in   data bits per OFDM symbol, latched on an accepted Start
//   DataIn     in   payload bit from the scrambler
//   DataValid  in   DataIn is valid
//   DataReady  out  payload bit is accepted this cycle (high throughout DATA)
//   EncIn      out  bit to the encoder (registered)
//   EncEn      out  encoder clock enable, EncIn is a real bit (registered)
//   EncClear   out  encoder shift-register clear, high during CLEAR
//   Busy       out  frame in progress (accepted Start until Done)
//   Done       out  one-cycle pulse after the last emitted bit
//   Error      out  one-cycle pulse when a Start is rejected (Length or NDbps 0)
//   NSym       out  number of OFDM symbols of the last completed frame
// -----------------------------------------------------------------------------
module conv_enc_frame_ctrl #(
  parameter int LEN_W     = 12,
  parameter int NDBPS_W   = 9,
  parameter int SVC_BITS  = 16,
  parameter int TAIL_BITS = 6
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [LEN_W-1:0]   Length,
  input  logic [NDBPS_W-1:0] NDbps,
  input  logic               DataIn,
  input  logic               DataValid,
  output logic               DataReady,
  output logic               EncIn,
  output logic               EncEn,
  output logic               EncClear,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [15:0]        NSym
);

  // Payload bit counter must hold 8*Length.
  localparam int CNT_W = LEN_W + 3;

  localparam logic [7:0]         SVC_LAST  = 8'(SVC_BITS - 1);
  localparam logic [7:0]         TAIL_LAST = 8'(TAIL_BITS - 1);
  localparam logic [NDBPS_W-1:0] NDBPS_ONE = NDBPS_W'(1);
  localparam logic [NDBPS_W-1:0] NDBPS_ZERO = NDBPS_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ZERO  = LEN_W'(0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SERVICE = 3'd2,
    S_DATA    = 3'd3,
    S_TAIL    = 3'd4,
    S_PAD     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [LEN_W-1:0]     len_r;
  logic [NDBPS_W-1:0]   ndbps_r;
  logic [NDBPS_W-1:0]   bit_cnt_r;      // position inside the current symbol
  logic [15:0]          sym_cnt_r;      // completed symbols so far
  logic [7:0]           phase_cnt_r;    // bit index inside SERVICE / TAIL
  logic [CNT_W-1:0]     data_cnt_r;     // payload bits transferred
  logic                 enc_in_r;
  logic                 enc_en_r;
  logic                 error_r;
  logic [15:0]          nsym_r;

  logic                 start_ok_s;
  logic                 emit_s;
  logic                 emit_bit_s;
  logic                 bit_wrap_s;
  logic [NDBPS_W-1:0]   bit_cnt_nxt_s;
  logic [15:0]          sym_cnt_nxt_s;
  logic                 data_last_s;
  logic                 svc_last_s;
  logic                 tail_last_s;

  // Datapath decode: acceptance, bit emission and symbol counter arithmetic.
  always_comb begin
    start_ok_s  = Start && (Length != LEN_ZERO) && (NDbps != NDBPS_ZERO);
    // A bit is produced on every SERVICE/TAIL/PAD cycle and on each DATA transfer.
    emit_s      = (state_r == S_SERVICE) || (state_r == S_TAIL) ||
                  (state_r == S_PAD) || ((state_r == S_DATA) && DataValid);
    emit_bit_s  = (state_r == S_DATA) ? DataIn : 1'b0;
    bit_wrap_s  = emit_s && (bit_cnt_r == (ndbps_r - NDBPS_ONE));
    if (!emit_s) begin
      bit_cnt_nxt_s = bit_cnt_r;
    end else if (bit_wrap_s) begin
      bit_cnt_nxt_s = NDBPS_ZERO;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + NDBPS_ONE;
    end
    sym_cnt_nxt_s = sym_cnt_r + {15'd0, bit_wrap_s};
    data_last_s   = (data_cnt_r == ({len_r, 3'b000} - CNT_ONE));
    svc_last_s    = (phase_cnt_r == SVC_LAST);
    tail_last_s   = (phase_cnt_r == TAIL_LAST);
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_nxt_s = S_SERVICE;
      end
      S_SERVICE: begin
        if (svc_last_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_SERVICE;
        end
      end
      S_DATA: begin
        if (DataValid && data_last_s) begin
          state_nxt_s = S_TAIL;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_TAIL: begin
        // PAD is skipped when the tail lands exactly on a symbol boundary.
        if (!tail_last_s) begin
          state_nxt_s = S_TAIL;
        end else if (bit_cnt_nxt_s == NDBPS_ZERO) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_PAD;
        end
      end
      S_PAD: begin
        if (bit_cnt_nxt_s == NDBPS_ZERO) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_PAD;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    DataReady = (state_r == S_DATA);
    EncClear  = (state_r == S_CLEAR);
    Busy      = (state_r != S_IDLE) && (state_r != S_DONE);
    Done      = (state_r == S_DONE);
  end

  // Frame parameters, counters and registered encoder-side outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      len_r       <= LEN_ZERO;
      ndbps_r     <= NDBPS_ZERO;
      bit_cnt_r   <= NDBPS_ZERO;
      sym_cnt_r   <= 16'd0;
      phase_cnt_r <= 8'd0;
      data_cnt_r  <= {CNT_W{1'b0}};
      enc_in_r    <= 1'b0;
      enc_en_r    <= 1'b0;
      error_r     <= 1'b0;
      nsym_r      <= 16'd0;
    end else begin
      if ((state_r == S_IDLE) && start_ok_s) begin
        len_r   <= Length;
        ndbps_r <= NDbps;
      end
      if (state_r == S_CLEAR) begin
        bit_cnt_r   <= NDBPS_ZERO;
        sym_cnt_r   <= 16'd0;
        phase_cnt_r <= 8'd0;
        data_cnt_r  <= {CNT_W{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_nxt_s;
        sym_cnt_r <= sym_cnt_nxt_s;
        // Phase counter restarts on every state change so TAIL starts at 0.
        if (state_nxt_s != state_r) begin
          phase_cnt_r <= 8'd0;
        end else if ((state_r == S_SERVICE) || (state_r == S_TAIL)) begin
          phase_cnt_r <= phase_cnt_r + 8'd1;
        end
        if ((state_r == S_DATA) && DataValid) begin
          data_cnt_r <= data_cnt_r + CNT_ONE;
        end
      end
      enc_en_r <= emit_s;
      enc_in_r <= emit_s & emit_bit_s;
      error_r  <= (state_r == S_IDLE) && Start && !start_ok_s;
      // The last emitted bit always closes a symbol, so this is the final count.
      if (state_nxt_s == S_DONE) begin
        nsym_r <= sym_cnt_nxt_s;
      end
    end
  end

  assign EncIn = enc_in_r;
  assign EncEn = enc_en_r;
  assign Error = error_r;
  assign NSym  = nsym_r;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_frame_ctrl
//
// Self-checking bench for conv_enc_frame_ctrl. Payload bits and valid patterns
// come from $urandom; the expected encoder stream is built from the frame
// rules (SERVICE zeros, payload, tail zeros, pad to a whole symbol).
// -----------------------------------------------------------------------------
module tb_conv_enc_frame_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [11:0] Length = 12'd0;
  logic [8:0]  NDbps = 9'd0;
  logic        DataIn = 1'b0;
  logic        DataValid = 1'b0;
  logic        DataReady;
  logic        EncIn;
  logic        EncEn;
  logic        EncClear;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] NSym;

  int n_tests = 0;
  int n_fail  = 0;

  conv_enc_frame_ctrl dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Length   (Length),
    .NDbps    (NDbps),
    .DataIn   (DataIn),
    .DataValid(DataValid),
    .DataReady(DataReady),
    .EncIn    (EncIn),
    .EncEn    (EncEn),
    .EncClear (EncClear),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .NSym     (NSym)
  );

  always #5 Clock = ~Clock;

  // Monitor history, sampled on the falling edge.
  int          cyc = 0;
  logic        got_bits[$];
  int          clear_cycs[$];
  int          done_cycs[$];
  logic [15:0] done_nsym[$];
  int          err_cnt = 0;
  int          busy_at_done = 0;
  int          bad_idle_in = 0;
  int          last_en_cyc = 0;

  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (EncEn) begin
      got_bits.push_back(EncIn);
      last_en_cyc = cyc;
    end
    if (!EncEn && EncIn) bad_idle_in = bad_idle_in + 1;
    if (EncClear) clear_cycs.push_back(cyc);
    if (Done) begin
      done_cycs.push_back(cyc);
      done_nsym.push_back(NSym);
      if (Busy) busy_at_done = busy_at_done + 1;
    end
    if (Error) err_cnt = err_cnt + 1;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs nframes frames of identical geometry; nframes==2 holds Start high.
  task automatic run_frame(input int len, input int nd, input int vmode,
                           input bit ones, input bit junk, input int nframes);
    logic pay[$];
    logic expq[$];
    int   idx = 0;
    int   base_bits, base_clr, base_done, base_err, base_busy, base_bad;
    int   exp_nsym, start_sz, mm;
    bit   tog = 1'b1;
    bit   done_ok = 1'b0;

    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < 8 * len; i++)
        pay.push_back(ones ? 1'b1 : 1'($urandom % 2));

    // Reference: SERVICE zeros, payload, tail zeros, pad to a symbol boundary.
    for (int f = 0; f < nframes; f++) begin
      start_sz = expq.size();
      for (int i = 0; i < 16; i++) expq.push_back(1'b0);
      for (int i = 0; i < 8 * len; i++) expq.push_back(pay[f * 8 * len + i]);
      for (int i = 0; i < 6; i++) expq.push_back(1'b0);
      while (((expq.size() - start_sz) % nd) != 0) expq.push_back(1'b0);
    end
    exp_nsym = (16 + 8 * len + 6 + nd - 1) / nd;

    @(negedge Clock); #1;
    base_bits = got_bits.size();
    base_clr  = clear_cycs.size();
    base_done = done_cycs.size();
    base_err  = err_cnt;
    base_busy = busy_at_done;
    base_bad  = bad_idle_in;
    Start  = 1'b1;
    Length = 12'(len);
    NDbps  = 9'(nd);
    DataValid = 1'b0;

    for (int k = 0; k < 5000; k++) begin
      @(negedge Clock); #1;
      if (k == 0) begin
        check_val("busy_on_start", Busy, 1);
        check_val("clear_pulse", EncClear, 1);
      end
      if (done_cycs.size() - base_done >= nframes) begin
        done_ok = 1'b1;
        break;
      end
      if (nframes == 1) begin
        Start = junk ? 1'($urandom % 2) : 1'b0;
        if (junk) begin
          Length = 12'($urandom % 4);
          NDbps  = 9'($urandom % 64);
        end
      end
      if (DataReady) begin
        case (vmode)
          0: DataValid = 1'b1;
          1: begin DataValid = tog; tog = ~tog; end
          default: DataValid = 1'($urandom % 2);
        endcase
      end else begin
        DataValid = 1'($urandom % 2);
      end
      if (DataValid && DataReady) begin
        DataIn = (idx < pay.size()) ? pay[idx] : 1'b0;
        idx++;
      end else begin
        DataIn = 1'($urandom % 2);
      end
    end
    Start = 1'b0;
    DataValid = 1'b0;
    check_val("done_seen", done_ok, 1);
    repeat (3) @(negedge Clock);
    #1;

    check_val("bit_count", got_bits.size() - base_bits, expq.size());
    check_val("enc_en_total", got_bits.size() - base_bits, nframes * exp_nsym * nd);
    mm = 0;
    for (int i = 0; i < expq.size() && (base_bits + i) < got_bits.size(); i++)
      if (got_bits[base_bits + i] !== expq[i]) mm++;
    check_val("bit_mismatches", mm, 0);
    check_val("payload_used", idx, pay.size());
    check_val("clear_count", clear_cycs.size() - base_clr, nframes);
    check_val("done_count", done_cycs.size() - base_done, nframes);
    check_val("no_error", err_cnt - base_err, 0);
    check_val("busy_low_at_done", busy_at_done - base_busy, 0);
    check_val("encin_idle_zero", bad_idle_in - base_bad, 0);
    if (done_nsym.size() > base_done) begin
      check_val("nsym_at_done", done_nsym[done_nsym.size() - 1], exp_nsym);
      check_val("done_after_last_bit", done_cycs[done_cycs.size() - 1], last_en_cyc);
    end
    check_val("nsym_held", NSym, exp_nsym);
    if (nframes == 2 && clear_cycs.size() > base_clr + 1 && done_cycs.size() > base_done)
      check_val("b2b_clear_gap", clear_cycs[base_clr + 1] - done_cycs[base_done], 2);
  endtask

  task automatic error_test();
    int base_bits;
    @(negedge Clock); #1;
    base_bits = got_bits.size();
    Start = 1'b1; Length = 12'd0; NDbps = 9'd24;
    @(negedge Clock); #1;
    check_val("err_len0", Error, 1);
    check_val("err_len0_busy", Busy, 0);
    Start = 1'b0;
    @(negedge Clock); #1;
    check_val("err_one_cycle", Error, 0);
    Start = 1'b1; Length = 12'd5; NDbps = 9'd0;
    @(negedge Clock); #1;
    check_val("err_ndbps0", Error, 1);
    Start = 1'b0;
    @(negedge Clock); #1;
    check_val("err_ndbps0_busy", Busy, 0);
    check_val("err_no_clear", EncClear, 0);
    check_val("err_no_bits", got_bits.size() - base_bits, 0);
  endtask

  task automatic reset_test();
    int  ready_seen = 0;
    bit  reached = 1'b0;
    @(negedge Clock); #1;
    Start = 1'b1; Length = 12'd4; NDbps = 9'd24;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clock); #1;
      Start = 1'b0;
      DataValid = 1'b1;
      DataIn = 1'($urandom % 2);
      if (DataReady) ready_seen++;
      if (ready_seen == 5) begin
        reached = 1'b1;
        break;
      end
    end
    check_val("reach_data", reached, 1);
    Reset = 1'b0;
    DataValid = 1'b0;
    @(negedge Clock); #1;
    check_val("midframe_reset_outs",
              {DataReady, EncIn, EncEn, EncClear, Busy, Done, Error}, 0);
    check_val("midframe_reset_nsym", NSym, 0);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    check_val("reset_outs", {DataReady, EncIn, EncEn, EncClear, Busy, Done, Error}, 0);
    check_val("reset_nsym", NSym, 0);
    Reset = 1'b1;

    run_frame(1, 24, 0, 1'b1, 1'b0, 1);   // 48 bits, NSym 2
    run_frame(1, 30, 0, 1'b1, 1'b0, 1);   // exactly one symbol, no pad
    run_frame(2, 48, 1, 1'b0, 1'b0, 1);   // alternating valid
    error_test();
    run_frame(3, 24, 2, 1'b0, 1'b1, 1);   // Start toggled while busy
    reset_test();
    run_frame(1, 24, 0, 1'b0, 1'b0, 1);   // clean frame after abort
    run_frame(1, 24, 0, 1'b1, 1'b0, 2);   // back-to-back frames
    for (int r = 0; r < 6; r++)
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(24, 216)), 2,
                1'b0, 1'($urandom % 2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
